// File: rtl/bin_to_bcd_display.sv
// Binary capture, sequential double-dabble conversion and
// multiplexed common-anode 7-segment display driver.
module bin_to_bcd_display #(
    parameter int WIDTH    = 4,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [WIDTH-1:0]    VALUE,
    input  logic                LOAD,
    output logic                BUSY,
    output logic [4*DIGITS-1:0] BCD,
    output logic                BCD_VALID,
    output logic [6:0]          SEG,
    output logic [DIGITS-1:0]   AN
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);

    // Beyond 4 digits every legal WIDTH fits, so the power check is skipped.
    if (WIDTH < 1 || WIDTH > 10 || DIGITS < 1 || SCAN_DIV < 1 ||
        (DIGITS < 4 && (10 ** DIGITS) <= (2 ** WIDTH) - 1)) begin : g_bad_cfg
        $error("bin_to_bcd_display: illegal WIDTH/DIGITS/SCAN_DIV");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_sr;
    logic [BCD_W-1:0]   r_scr;
    logic [BCD_W-1:0]   w_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_valid;

    logic [SCAN_W-1:0]  r_scan;
    logic [IDX_W-1:0]   r_idx;
    logic [6:0]         r_seg;
    logic [DIGITS-1:0]  r_an;
    logic [3:0]         w_dig;
    logic               w_blank;
    logic               w_zero;
    logic [DIGITS-1:0]  w_an;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (LOAD) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == CNT_W'(1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scr[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sr    <= '0;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (LOAD) begin
                        r_sr  <= VALUE;
                        r_scr <= '0;
                        r_cnt <= CNT_W'(WIDTH);
                    end
                end
                S_SHIFT: begin
                    r_scr <= {w_adj[BCD_W-2:0], r_sr[WIDTH-1]};
                    r_sr  <= r_sr << 1;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_DONE: begin
                    r_bcd   <= r_scr;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Display only ever reads r_bcd, so partial results never show.
    always_comb begin
        w_dig   = 4'd0;
        w_blank = 1'b0;
        w_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero = w_zero && (r_bcd[4*i +: 4] == 4'd0);
            if (IDX_W'(i) == r_idx) begin
                w_dig   = r_bcd[4*i +: 4];
                w_blank = (BLANK_LZ != 0) && (i != 0) && w_zero;
            end
        end
        w_an = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == r_idx && !w_blank) w_an[i] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_seg  <= 7'h7F;
            r_an   <= '1;
        end else begin
            r_seg <= w_blank ? 7'h7F : f_seg(w_dig);
            r_an  <= w_an;
            if (r_scan == SCAN_MAX) begin
                r_scan <= '0;
                r_idx  <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
        end
    end

    assign BUSY      = (r_state != S_IDLE);
    assign BCD       = r_bcd;
    assign BCD_VALID = r_valid;
    assign SEG       = r_seg;
    assign AN        = r_an;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Scoreboard bench for bin_to_bcd_display: conversion results,
// latency, BUSY timing and scanned display outputs.
module tb_bin_to_bcd_display;

    localparam int WIDTH    = 4;
    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [WIDTH-1:0] VALUE;
    logic             LOAD;
    logic             BUSY;
    logic [7:0]       BCD;
    logic             BCD_VALID;
    logic [6:0]       SEG;
    logic [1:0]       AN;

    bin_to_bcd_display #(
        .WIDTH    (WIDTH),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (1)
    ) u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .VALUE     (VALUE),
        .LOAD      (LOAD),
        .BUSY      (BUSY),
        .BCD       (BCD),
        .BCD_VALID (BCD_VALID),
        .SEG       (SEG),
        .AN        (AN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] bcd;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         m_cnt = 0;
    int         m_sc  = 0;
    int         m_idx = 0;
    logic [7:0] m_bcd = 8'h00;
    int         n_valid = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] bcd_of(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000, 7'b0000000,
                               7'b0010000};
        return (d > 4'd9) ? 7'h7F : t[d];
    endfunction

    task automatic model_reset();
        q.delete();
        m_cnt = 0;
        m_sc  = 0;
        m_idx = 0;
        m_bcd = 8'h00;
    endtask

    // Reference model plus monitor, evaluated once per rising edge.
    initial begin
        logic [3:0] d;
        logic       blank;
        logic [6:0] e_seg;
        logic [1:0] e_an;
        exp_t       e;
        forever begin
            @(posedge CLK);
            cyc++;
            if (RST_N) begin
                d     = (m_idx == 0) ? m_bcd[3:0] : m_bcd[7:4];
                blank = (m_idx == 1) && (m_bcd[7:4] == 4'd0);
                e_seg = blank ? 7'h7F : seg_of(d);
                e_an  = blank ? 2'b11 : ((m_idx == 0) ? 2'b10 : 2'b01);
                if (m_sc == SCAN_DIV - 1) begin
                    m_sc  = 0;
                    m_idx = (m_idx + 1) % DIGITS;
                end else begin
                    m_sc++;
                end
                if (m_cnt > 0) begin
                    m_cnt--;
                end else if (LOAD) begin
                    q.push_back('{bcd_of(int'(VALUE)), cyc + WIDTH + 1});
                    m_cnt = WIDTH + 1;
                end
                #1;
                chk("busy", BUSY, m_cnt != 0);
                chk("an", AN, e_an);
                chk("seg", SEG, e_seg);
                if (BCD_VALID) begin
                    n_valid++;
                    if (q.size() == 0) begin
                        chk("spurious_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("bcd", BCD, e.bcd);
                        chk("latency", cyc, e.due);
                        m_bcd = e.bcd;
                    end
                end else if (q.size() > 0 && q[0].due == cyc) begin
                    chk("valid_missing", 0, 1);
                    e = q.pop_front();
                    m_bcd = e.bcd;
                end
            end
        end
    end

    task automatic convert(input int v, input int hold);
        @(negedge CLK);
        VALUE = WIDTH'(v);
        LOAD  = 1'b1;
        @(negedge CLK);
        LOAD  = 1'b0;
        VALUE = WIDTH'(v + 5);
        repeat (hold) @(negedge CLK);
    endtask

    initial begin
        int nv;
        RST_N = 1'b0;
        LOAD  = 1'b0;
        VALUE = '0;
        model_reset();
        repeat (3) begin
            @(negedge CLK);
            chk("rst_busy", BUSY, 0);
            chk("rst_bcd", BCD, 8'h00);
            chk("rst_valid", BCD_VALID, 0);
            chk("rst_an", AN, 2'b11);
            chk("rst_seg", SEG, 7'h7F);
        end
        RST_N = 1'b1;
        repeat (12) @(negedge CLK);

        convert(13, 16);
        convert(9, 16);
        convert(15, 16);
        convert(0, 12);

        nv = n_valid;
        LOAD = 1'b1;
        for (int i = 0; i < 30; i++) begin
            VALUE = WIDTH'(i + 3);
            @(negedge CLK);
        end
        LOAD = 1'b0;
        repeat (8) @(negedge CLK);
        chk("held_load_count", n_valid - nv, 5);

        convert(7, 10);
        @(negedge CLK);
        VALUE = 4'd7;
        LOAD  = 1'b1;
        @(negedge CLK);
        LOAD  = 1'b0;
        repeat (2) @(negedge CLK);
        chk("busy_before_abort", BUSY, 1);
        RST_N = 1'b0;
        #1;
        chk("busy_async", BUSY, 0);
        chk("bcd_async", BCD, 8'h00);
        model_reset();
        repeat (3) begin
            @(negedge CLK);
            chk("abort_valid", BCD_VALID, 0);
            chk("abort_busy", BUSY, 0);
        end
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        convert(7, 12);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge CLK);
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_display.md
Name: bin_to_bcd_display

Overview:
- Downstream consumer of the up/down counter.
- Captures the counter's binary VALUE on request and converts it to packed BCD with a sequential shift-and-add-3 (double-dabble) engine.
- Time-multiplexes the last completed result onto a common-anode 7-segment display, with optional leading-zero blanking.
- Sits between the counter stage and the board display pins.

Parameters:
- WIDTH, 4: binary input width, legal range 1..10.
- DIGITS, 2: BCD digits. 10^DIGITS must exceed 2^WIDTH-1; any other combination is an illegal configuration.
- SCAN_DIV, 50000: clock cycles per digit scan slot, >= 1.
- BLANK_LZ, 1: 1 = blank leading zero digits, 0 = show all digits.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- VALUE  input  WIDTH  binary value from the counter.
- LOAD  input  1  capture/convert request, sampled on the rising edge.
- BUSY  output  1  conversion in progress.
- BCD  output  4*DIGITS  last completed result; digit i is BCD[4i+3:4i], digit 0 = ones.
- BCD_VALID  output  1  one-cycle pulse when BCD updates.
- SEG  output  7  active-low segments; SEG[0]=a ... SEG[6]=g.
- AN  output  DIGITS  active-low digit enables, at most one low.

Behaviour:
- Reset (async, RST_N low):
  - Conversion FSM = IDLE; BUSY=0, BCD_VALID=0, BCD=0.
  - Scan counter=0, digit index=0; SEG=7'h7F, AN=all ones.
  - Any conversion in progress is aborted immediately with no BCD_VALID.
- Conversion FSM (IDLE, SHIFT, DONE):
  - IDLE: LOAD=1 at edge k → shift register <= VALUE, scratch <= 0, step count <= WIDTH, BUSY <= 1, go to SHIFT.
  - SHIFT: each edge, every scratch digit >= 5 gets +3, then {scratch, shift reg} shifts left by 1. After WIDTH steps (edge k+WIDTH), go to DONE.
  - DONE (edge k+WIDTH+1): BCD <= scratch, BCD_VALID <= 1 for exactly one cycle, BUSY <= 0, go to IDLE.
  - BUSY is high for WIDTH+1 cycles. Maximum throughput is one conversion per WIDTH+2 cycles.
  - LOAD sampled while in SHIFT or DONE is ignored, not queued.
  - VALUE changes after capture do not affect the result in flight.
- Display scan:
  - Free-running scan counter 0..SCAN_DIV-1. On terminal count, digit index advances i → i+1, wrapping DIGITS-1 → 0.
  - SCAN_DIV=1: the index advances every cycle.
  - AN and SEG are registered from the current index: AN[i]=0 and SEG=decode(BCD digit i), one cycle after the index changes.
  - The first cycle after reset release shows digit 0.
  - The display always reads the BCD register, never scratch, so no partial results are displayed.
- Decode, active-low, g..a order:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 decode to blank (7'h7F).
- Blanking, when BLANK_LZ=1:
  - Digit i>0 is blanked when it and all higher digits are 0: SEG=7'h7F and AN[i]=1 for that slot.
  - Digit 0 is never blanked.

Test Plan (WIDTH=4, DIGITS=2, SCAN_DIV=4, BLANK_LZ=1):
1. RST_N low for 3 cycles then high → during reset BUSY=0, BCD=8'h00, BCD_VALID=0, AN=2'b11, SEG=7'h7F. First cycle after release: AN=2'b10, SEG=7'b1000000. Digit 1 slot: AN=2'b11 (blanked).
2. VALUE=13, LOAD pulsed at edge k → BUSY=1 from edge k through edge k+5. BCD_VALID=1 only after edge k+5. BCD=8'h13.
3. VALUE=9, LOAD pulse → BCD=8'h09. Digit 0 slot: AN=2'b10, SEG=7'b0010000. Digit 1 slot: AN=2'b11, SEG=7'h7F. Each slot lasts 4 cycles.
4. VALUE=15, LOAD pulse → BCD=8'h15. Digit 1 slot: AN=2'b01, SEG=7'b1111001. Digit 0 slot: AN=2'b10, SEG=7'b0010010. AN alternates every 4 cycles.
5. LOAD held high while VALUE increments each cycle → captures occur every 6 cycles only. Each BCD equals the BCD of the VALUE sampled at its capture edge. Exactly one BCD_VALID per capture.
6. RST_N pulsed low during SHIFT after converting 7 → BUSY drops asynchronously, BCD=8'h00, no BCD_VALID. A subsequent LOAD with VALUE=7 yields BCD=8'h07 with normal latency.
